// File: rtl/tt_sub_pkg.sv
// ---------------------------------------------------------------------------
// tt_sub_pkg
// Shared types and constants for the bit-serial tile subtractor.
//   - subState_e : controller states (IDLE, GOT_A, RUN, DONE)
//   - DATA_W / CNT_W : operand width and bit-counter width
//   - UIO_OE_VAL : fixed bidirectional pin direction (upper nibble out)
//   - *_BIT : positions of the status flags on uio_out
//   - packFlags : assembles the uio_out status byte from individual flags
// Optional feature macro used by the top level: SUB_SIGNED_OVF_EN
// ---------------------------------------------------------------------------
package tt_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } subState_e;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  localparam int BORROW_BIT = 7;
  localparam int DONE_BIT   = 6;
  localparam int OVF_BIT    = 5;
  localparam int BUSY_BIT   = 4;

  // Lower nibble of the status byte is always zero; it is an input nibble
  // on the tile and never driven.
  function automatic logic [7:0] packFlags(input logic borrowFlag,
                                           input logic doneFlag,
                                           input logic ovfFlag,
                                           input logic busyFlag);
    logic [7:0] flags;
    flags             = 8'h00;
    flags[BORROW_BIT] = borrowFlag;
    flags[DONE_BIT]   = doneFlag;
    flags[OVF_BIT]    = ovfFlag;
    flags[BUSY_BIT]   = busyFlag;
    return flags;
  endfunction

endpackage

// File: rtl/serial_sub_bit.sv
// ---------------------------------------------------------------------------
// serial_sub_bit
// Combinational single-bit full subtractor: computes a - b - bin.
// Ports:
//   a_i, b_i  : minuend / subtrahend bit
//   bin_i     : borrow in from the previous (less significant) bit
//   d_o       : difference bit
//   bout_o    : borrow out to the next (more significant) bit
// ---------------------------------------------------------------------------
module serial_sub_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  // Borrow when b exceeds a outright, or when they are equal and a borrow
  // is already pending from below.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tt_um_serial_subtractor
// Bit-serial 8-bit subtractor on the TinyTapeout tile interface. Operand A
// then operand B arrive as rising-edge strobed bytes on ui_in; A - B is then
// computed LSB-first, one bit per enabled clock, and published on uo_out.
// Ports:
//   clk     : tile clock
//   rst_n   : asynchronous active-low reset
//   ena     : tile enable, all state holds while low
//   ui_in   : operand byte
//   uio_in  : bit 0 = valid strobe, bits 7:1 unused
//   uo_out  : last completed difference (mod 256)
//   uio_out : [7] borrow, [6] done, [5] ovf, [4] busy, [3:0] zero
//   uio_oe  : constant 8'hF0
// Configuration macro: SUB_SIGNED_OVF_EN (when defined, the signed-overflow
// flag is computed and registered; otherwise uio_out[5] is tied low).
// ---------------------------------------------------------------------------
module tt_um_serial_subtractor
  import tt_sub_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  subState_e          state_q, state_d;
  logic               valid_q;
  logic [DATA_W-1:0]  opA_q, opA_d;
  logic [DATA_W-1:0]  opB_q, opB_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               bor_q, bor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               borrowFlag_q, borrowFlag_d;
  logic               ovfFlag;

  logic               capture;
  logic               diffBit;
  logic               borOut;
  logic [DATA_W-1:0]  finalDiff;

  // Upper uio_in bits carry no function on this tile.
  logic               unusedUioBits;
  assign unusedUioBits = ^uio_in[7:1];

  // A capture is a fresh rising edge of valid; holding valid high only
  // counts once because valid_q follows it one enabled cycle later.
  assign capture = uio_in[0] & ~valid_q;

  serial_sub_bit uBit (
    .a_i    (opA_q[cnt_q]),
    .b_i    (opB_q[cnt_q]),
    .bin_i  (bor_q),
    .d_o    (diffBit),
    .bout_o (borOut)
  );

  // On the last bit the fresh difference bit lands in the MSB and the
  // previously shifted bits fill the rest.
  assign finalDiff = {diffBit, shift_q[DATA_W-1:1]};

  // Next-state and datapath updates. ena gating lives in the register
  // block, so this logic simply describes one enabled step.
  always_comb begin
    state_d      = state_q;
    opA_d        = opA_q;
    opB_d        = opB_q;
    shift_d      = shift_q;
    bor_d        = bor_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    borrowFlag_d = borrowFlag_q;

    case (state_q)
      IDLE: begin
        if (capture) begin
          opA_d   = ui_in;
          state_d = GOT_A;
        end
      end

      GOT_A: begin
        if (capture) begin
          opB_d   = ui_in;
          shift_d = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        shift_d = finalDiff;
        bor_d   = borOut;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d     = finalDiff;
          borrowFlag_d = borOut;
          state_d      = DONE;
        end
      end

      DONE: begin
        if (capture) begin
          opA_d   = ui_in;
          state_d = GOT_A;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Main register bank; everything, including the edge detector, freezes
  // while ena is low so no capture is lost or invented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      opA_q        <= '0;
      opB_q        <= '0;
      shift_q      <= '0;
      bor_q        <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      borrowFlag_q <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      valid_q      <= uio_in[0];
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      shift_q      <= shift_d;
      bor_q        <= bor_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      borrowFlag_q <= borrowFlag_d;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands of opposite sign and the result sign differs
  // from A. Only refreshed on the RUN -> DONE step.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && cnt_q == CNT_LAST) begin
      ovf_d = (opA_q[DATA_W-1] ^ opB_q[DATA_W-1]) &
              (finalDiff[DATA_W-1] ^ opA_q[DATA_W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ena) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovfFlag = ovf_q;
`else
  assign ovfFlag = 1'b0;
`endif

  assign uo_out  = result_q;
  assign uio_out = packFlags(borrowFlag_q, state_q == DONE, ovfFlag,
                             state_q == RUN);
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: doc/tt_um_serial_subtractor.md
# tt_um_serial_subtractor

Bit-serial 8-bit subtractor, the counterpart of the team's combinational tile adder. It occupies the same TinyTapeout tile interface. Two operands arrive as consecutive strobed bytes on `ui_in`, and the block computes A − B one bit per clock through a single-bit full subtractor. It presents the difference on `uo_out` with borrow, done, busy and (optionally) signed-overflow flags on the upper `uio` nibble.

## Interface
Parameters: none (widths fixed by tile pinout).
- `clk`  in  1  tile clock
- `rst_n`  in  1  asynchronous active-low reset; one clock; all state cleared on assertion
- `ena`  in  1  tile enable; when low, all registers hold (no state advance, no capture)
- `ui_in`  in  8  operand data byte
- `uio_in`  in  8  bit 0 = `valid` strobe; bits 7:1 ignored
- `uo_out`  out  8  result register: last completed A − B (mod 256)
- `uio_out`  out  8  [7] borrow, [6] done, [5] ovf, [4] busy, [3:0] = 0
- `uio_oe`  out  8  constant 8'hF0 (upper nibble driven, lower nibble input)

## Operation
- `valid` is registered once (`valid_q`). A capture event is a rising edge: `uio_in[0]` = 1 with `valid_q` = 0, while `ena` = 1.
- FSM states:
  - IDLE: capture event → latch `ui_in` as A; go to GOT_A.
  - GOT_A: capture event → latch `ui_in` as B; clear shift result and borrow; bit counter = 0; go to RUN.
  - RUN: each enabled cycle, compute bit i = A[i] ^ B[i] ^ bor and next bor = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bor). Shift the bit into the shift register LSB-first and increment the counter. On counter = 7, load the result register, borrow, ovf and done; go to DONE. Capture events in RUN are ignored, and the edge detector still tracks.
  - DONE: outputs hold. Capture event → latch A, clear done, go to GOT_A.
- Arithmetic: D = (A − B) mod 256. borrow = 1 iff A < B unsigned. ovf = (A[7] ≠ B[7]) & (D[7] ≠ A[7]).
- busy = 1 exactly in RUN. done = 1 exactly in DONE.
- `uo_out`, borrow and ovf change only on the DONE transition. They hold the previous result through IDLE, GOT_A and RUN.
- Reset mid-operation: FSM returns to IDLE. All outputs except `uio_oe` go to 0 and the partial result is discarded.
- `valid` held high across states produces one capture only; it must drop for at least one sampled cycle before the next capture.

## Timing
- Reset values: `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'hF0, FSM = IDLE, `valid_q` = 0.
- B captured on clock edge M. RUN covers edges M+1..M+8. done, borrow, ovf and `uo_out` are valid after edge M+8. Latency is 8 enabled cycles from B capture.
- Each `ena` = 0 cycle stretches latency by one cycle. The edge detector also holds, so no event is lost or invented.
- Minimum operand-to-operand spacing: two capture edges need `valid` low for at least one cycle between them. Fastest full transaction is A, B, then 8 cycles.

## Configuration
- `SUB_SIGNED_OVF_EN` defined: ovf computed as above and driven on `uio_out[5]`.
- Not defined: ovf logic and its register absent; `uio_out[5]` tied 0. All other behaviour is identical.

## Structure
- Package `tt_sub_pkg`:
  - state enum (IDLE, GOT_A, RUN, DONE)
  - `DATA_W` = 8, `CNT_W` = 3
  - `UIO_OE_VAL` = 8'hF0
  - flag bit-index constants (BORROW_BIT = 7, DONE_BIT = 6, OVF_BIT = 5, BUSY_BIT = 4)
- Sub-module `serial_sub_bit`: combinational single-bit full subtractor (a, b, bin → d, bout). The top level owns the FSM, the registers and the borrow flop.

## Test plan
- A = 200, B = 55 → after 8 cycles `uo_out` = 145, borrow = 0, done = 1, ovf = 0.
- A = 55, B = 200 → `uo_out` = 0x6F (111), borrow = 1; ovf = 0 (macro on).
- A = 0x80, B = 0x01 → `uo_out` = 0x7F, borrow = 0, ovf = 1 with `SUB_SIGNED_OVF_EN`, ovf = 0 without.
- `valid` held high 20 cycles with `ui_in` = 0x10 → only A captured; FSM stays GOT_A, busy = 0, `uo_out` unchanged.
- A = 9, B = 3; rising `valid` with new data on the 4th RUN cycle → ignored, result = 6. Assert `rst_n` low on a later RUN cycle → all outputs 0 immediately, `uio_oe` = 0xF0, FSM IDLE.
- A = 10, B = 4, `ena` low for 3 cycles during RUN → done after 11 cycles, `uo_out` = 6, borrow = 0.
